// File: rtl/image_sram_arbiter_pkg.sv
// Shared types and helpers for the three-requester image SRAM arbiter.
// Requester ids: loader = 0, dither engine = 1, readout = 2.
package sram_arb_pkg;

  typedef logic [0:0] arb_state_t;

  localparam arb_state_t ARB_IDLE = 1'b0;
  localparam arb_state_t ARB_BUSY = 1'b1;

  typedef enum logic [1:0] {
    REQ_LOADER  = 2'd0,
    REQ_DITHER  = 2'd1,
    REQ_READOUT = 2'd2
  } req_id_t;

  // Next requester id in round-robin order, wrapping readout back to loader.
  function automatic logic [1:0] rr_next(input logic [1:0] id);
    return (id == REQ_READOUT) ? REQ_LOADER : id + 2'd1;
  endfunction

  function automatic logic [2:0] id_onehot(input logic [1:0] id);
    return 3'b001 << id;
  endfunction

endpackage

// File: rtl/image_sram_arbiter_if.sv
// Requester, status and SRAM-side signals of the image SRAM arbiter.
// The arbiter takes the slave view; requesters and the SRAM model take the master view.
interface image_sram_arbiter_if #(
  parameter int IMAGE_ADDR_WIDTH = 8,
  parameter int RGB_SIZE         = 8
);

  logic [2:0]                  req;
  logic [2:0]                  we;
  logic [2:0]                  lock;
  logic [IMAGE_ADDR_WIDTH-1:0] addr0;
  logic [IMAGE_ADDR_WIDTH-1:0] addr1;
  logic [IMAGE_ADDR_WIDTH-1:0] addr2;
  logic [RGB_SIZE-1:0]         wdata0;
  logic [RGB_SIZE-1:0]         wdata1;
  logic [RGB_SIZE-1:0]         wdata2;

  logic [2:0]                  gnt;
  logic [2:0]                  rvalid;
  logic [RGB_SIZE-1:0]         rdata;
  logic [1:0]                  owner;
  logic                        busy;
  logic                        preempt;

  logic [IMAGE_ADDR_WIDTH-1:0] sram_addr;
  logic [RGB_SIZE-1:0]         sram_wdata;
  logic                        sram_we;
  logic                        sram_re;
  logic [RGB_SIZE-1:0]         sram_rdata;

  modport slave (
    input  req, we, lock, addr0, addr1, addr2, wdata0, wdata1, wdata2, sram_rdata,
    output gnt, rvalid, rdata, owner, busy, preempt,
           sram_addr, sram_wdata, sram_we, sram_re
  );

  modport master (
    output req, we, lock, addr0, addr1, addr2, wdata0, wdata1, wdata2, sram_rdata,
    input  gnt, rvalid, rdata, owner, busy, preempt,
           sram_addr, sram_wdata, sram_we, sram_re
  );

endinterface

// File: rtl/image_sram_arbiter_rr_pick3.sv
// Combinational 3-way round-robin selector: search starts one past last_owner_i
// and skips requesters that are not asking.
module rr_pick3
  import sram_arb_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] last_owner_i,
  output logic [1:0] winner_o,
  output logic       valid_o
);

  logic [1:0] cand0;
  logic [1:0] cand1;
  logic [1:0] cand2;

  always_comb begin
    cand0    = rr_next(last_owner_i);
    cand1    = rr_next(cand0);
    cand2    = rr_next(cand1);
    valid_o  = |req_i;
    winner_o = 2'd0;
    if (req_i[cand0]) begin
      winner_o = cand0;
    end else if (req_i[cand1]) begin
      winner_o = cand1;
    end else if (req_i[cand2]) begin
      winner_o = cand2;
    end
  end

endmodule

// File: rtl/image_sram_arbiter.sv
// Single-port image SRAM arbiter for loader, dither engine and readout, with
// grant locking, hold-count preemption and per-issuer read-valid tagging.
//
// state    | meaning
// ARB_IDLE | no grant; any request is arbitrated at the next edge
// ARB_BUSY | owner_q holds the grant; its accesses pass straight to the SRAM
module image_sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int IMAGE_ADDR_WIDTH = 8,
  parameter int RGB_SIZE         = 8,
  parameter int MAX_HOLD         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  image_sram_arbiter_if.slave  bus
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_t                  state_q, state_d;
  logic [1:0]                  owner_q, owner_d;
  logic [1:0]                  last_owner_q, last_owner_d;
  logic [HW-1:0]               hold_q, hold_d;
  logic [2:0]                  rvalid_q, rvalid_d;
  logic                        preempt_q, preempt_d;

  logic                        busy;
  logic                        own_req;
  logic                        own_we;
  logic                        own_lock;
  logic [IMAGE_ADDR_WIDTH-1:0] own_addr;
  logic [RGB_SIZE-1:0]         own_wdata;
  logic [2:0]                  own_mask;
  logic [2:0]                  others;
  logic                        accept;
  logic                        at_limit;
  logic                        force_rel;
  logic                        release_now;
  logic [2:0]                  pick_req;
  logic [1:0]                  winner;
  logic                        pick_valid;

  always_comb begin
    own_req   = bus.req[0];
    own_we    = bus.we[0];
    own_lock  = bus.lock[0];
    own_addr  = bus.addr0;
    own_wdata = bus.wdata0;
    unique case (owner_q)
      2'd1: begin
        own_req   = bus.req[1];
        own_we    = bus.we[1];
        own_lock  = bus.lock[1];
        own_addr  = bus.addr1;
        own_wdata = bus.wdata1;
      end
      2'd2: begin
        own_req   = bus.req[2];
        own_we    = bus.we[2];
        own_lock  = bus.lock[2];
        own_addr  = bus.addr2;
        own_wdata = bus.wdata2;
      end
      default: ;
    endcase
  end

  assign busy     = (state_q == ARB_BUSY);
  assign own_mask = id_onehot(owner_q);
  assign others   = bus.req & ~own_mask;
  assign accept   = busy & own_req;

  // Limit is reached by the access that brings the count to MAX_HOLD; once
  // saturated, every later access also qualifies so a late arrival still preempts.
  assign at_limit    = (hold_q >= HW'(MAX_HOLD - 1));
  assign force_rel   = accept & at_limit & (|others);
  assign release_now = busy & ((accept & ~own_lock) | (~own_req & ~own_lock) | force_rel);

  // While busy the owner is excluded so a release hands over without a bubble.
  assign pick_req = busy ? others : bus.req;

  rr_pick3 u_pick (
    .req_i        (pick_req),
    .last_owner_i (last_owner_q),
    .winner_o     (winner),
    .valid_o      (pick_valid)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    hold_d       = hold_q;
    preempt_d    = 1'b0;
    rvalid_d     = (accept & ~own_we) ? own_mask : 3'b000;

    if (accept && (hold_q != HW'(MAX_HOLD))) begin
      hold_d = hold_q + HW'(1);
    end

    if (state_q == ARB_IDLE) begin
      if (pick_valid) begin
        state_d      = ARB_BUSY;
        owner_d      = winner;
        last_owner_d = winner;
        hold_d       = '0;
      end
    end else if (release_now) begin
      preempt_d = force_rel;
      if (pick_valid) begin
        owner_d      = winner;
        last_owner_d = winner;
        hold_d       = '0;
      end else begin
        state_d = ARB_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= 2'd0;
      last_owner_q <= REQ_READOUT;
      hold_q       <= '0;
      rvalid_q     <= 3'b000;
      preempt_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      hold_q       <= hold_d;
      rvalid_q     <= rvalid_d;
      preempt_q    <= preempt_d;
    end
  end

  assign bus.gnt        = busy ? own_mask : 3'b000;
  assign bus.busy       = busy;
  assign bus.owner      = owner_q;
  assign bus.preempt    = preempt_q;
  assign bus.rvalid     = rvalid_q;
  assign bus.rdata      = bus.sram_rdata;
  assign bus.sram_addr  = accept ? own_addr : '0;
  assign bus.sram_wdata = accept ? own_wdata : '0;
  assign bus.sram_we    = accept & own_we;
  assign bus.sram_re    = accept & ~own_we;

endmodule

// File: tb/tb_image_sram_arbiter.sv
// Scoreboard bench for image_sram_arbiter: stimulus queues expected SRAM accesses,
// read returns and per-cycle status; a negedge monitor pops and compares.
module tb_image_sram_arbiter;

  typedef struct packed {
    logic [2:0] gnt;
    logic       we;
    logic       re;
    logic [7:0] addr;
    logic [7:0] wdata;
  } acc_t;

  typedef struct packed {
    logic [2:0] rv;
    logic [7:0] data;
  } rd_t;

  typedef struct packed {
    logic [2:0] gnt;
    logic       busy;
    logic [1:0] owner;
    logic       we;
    logic       re;
    logic [2:0] rvalid;
    logic       preempt;
  } snap_t;

  typedef struct packed {
    int    id;
    logic  bz;
    snap_t s;
  } snapx_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  image_sram_arbiter_if #(.IMAGE_ADDR_WIDTH(8), .RGB_SIZE(8)) bus ();

  image_sram_arbiter #(
    .IMAGE_ADDR_WIDTH (8),
    .RGB_SIZE         (8),
    .MAX_HOLD         (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SRAM model: location a holds a ^ 8'h5A; writes never target read addresses.
  always @(posedge clk) begin
    if (bus.sram_re) bus.sram_rdata <= bus.sram_addr ^ 8'h5A;
  end

  acc_t   acc_q[$];
  rd_t    rd_q[$];
  snapx_t snap_q[$];
  int     snap_no = 0;
  bit     done = 1'b0;
  int     n_vec = 0;
  int     n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rq(input logic [1:0] i, input logic r, input logic w, input logic l,
                        input logic [7:0] a, input logic [7:0] d);
    bus.req[i]  = r;
    bus.we[i]   = w;
    bus.lock[i] = l;
    case (i)
      2'd0: begin bus.addr0 = a; bus.wdata0 = d; end
      2'd1: begin bus.addr1 = a; bus.wdata1 = d; end
      default: begin bus.addr2 = a; bus.wdata2 = d; end
    endcase
  endtask

  task automatic exp_acc(input logic [2:0] g, input logic w, input logic [7:0] a, input logic [7:0] d);
    acc_q.push_back({g, w, ~w, a, d});
  endtask

  task automatic exp_rd(input logic [2:0] rv, input logic [7:0] d);
    rd_q.push_back({rv, d});
  endtask

  task automatic snap(input logic [2:0] g, input logic b, input logic [1:0] o, input logic w,
                      input logic r, input logic [2:0] rv, input logic p, input logic bz);
    snapx_t sx;
    sx.id = snap_no;
    sx.bz = bz;
    sx.s  = {g, b, o, w, r, rv, p};
    snap_q.push_back(sx);
    snap_no++;
  endtask

  initial begin : monitor
    snapx_t sx;
    snap_t  obs;
    acc_t   ea, oa;
    rd_t    er, orv;
    forever begin
      @(negedge clk);
      if (snap_q.size() > 0) begin
        sx  = snap_q.pop_front();
        obs = {bus.gnt, bus.busy, bus.owner, bus.sram_we, bus.sram_re, bus.rvalid, bus.preempt};
        if (!sx.s.busy) obs.owner = sx.s.owner;
        n_vec++;
        if (obs !== sx.s) begin
          n_err++;
          $display("FAIL snap%0d: got gnt=%b busy=%b owner=%0d we=%b re=%b rvalid=%b preempt=%b, want gnt=%b busy=%b owner=%0d we=%b re=%b rvalid=%b preempt=%b",
                   sx.id, obs.gnt, obs.busy, obs.owner, obs.we, obs.re, obs.rvalid, obs.preempt,
                   sx.s.gnt, sx.s.busy, sx.s.owner, sx.s.we, sx.s.re, sx.s.rvalid, sx.s.preempt);
        end
        if (sx.bz) begin
          n_vec++;
          if (bus.sram_addr !== 8'h00 || bus.sram_wdata !== 8'h00) begin
            n_err++;
            $display("FAIL snap%0d_bus: got addr=%h wdata=%h, want 00 00", sx.id, bus.sram_addr, bus.sram_wdata);
          end
        end
      end
      if (bus.sram_we === 1'b1 || bus.sram_re === 1'b1) begin
        n_vec++;
        oa = {bus.gnt, bus.sram_we, bus.sram_re, bus.sram_addr, bus.sram_wdata};
        if (acc_q.size() == 0) begin
          n_err++;
          $display("FAIL access: unexpected gnt=%b we=%b re=%b addr=%h wdata=%h", oa.gnt, oa.we, oa.re, oa.addr, oa.wdata);
        end else begin
          ea = acc_q.pop_front();
          if (oa !== ea) begin
            n_err++;
            $display("FAIL access: got gnt=%b we=%b re=%b addr=%h wdata=%h, want gnt=%b we=%b re=%b addr=%h wdata=%h",
                     oa.gnt, oa.we, oa.re, oa.addr, oa.wdata, ea.gnt, ea.we, ea.re, ea.addr, ea.wdata);
          end
        end
      end
      if (bus.rvalid !== 3'b000) begin
        n_vec++;
        orv = {bus.rvalid, bus.rdata};
        if (rd_q.size() == 0) begin
          n_err++;
          $display("FAIL rdata: unexpected rvalid=%b rdata=%h", orv.rv, orv.data);
        end else begin
          er = rd_q.pop_front();
          if (orv !== er) begin
            n_err++;
            $display("FAIL rdata: got rvalid=%b rdata=%h, want rvalid=%b rdata=%h", orv.rv, orv.data, er.rv, er.data);
          end
        end
      end
      if (done) break;
    end
    n_vec++;
    if (acc_q.size() != 0 || rd_q.size() != 0 || snap_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: got acc=%0d rd=%0d snap=%0d still queued, want 0 0 0", acc_q.size(), rd_q.size(), snap_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: got no end of stimulus, want finish before 20000ns");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bus.req = 3'b000; bus.we = 3'b000; bus.lock = 3'b000;
    bus.addr0 = 8'h00; bus.addr1 = 8'h00; bus.addr2 = 8'h00;
    bus.wdata0 = 8'h00; bus.wdata1 = 8'h00; bus.wdata2 = 8'h00;

    // reset state
    tick(); snap(3'b000, 0, 2'd0, 0, 0, 3'b000, 0, 1);
    tick(); rst = 1'b1; snap(3'b000, 0, 2'd0, 0, 0, 3'b000, 0, 1);
    tick();

    // all three request one write each: loader, dither, readout back to back
    exp_acc(3'b001, 1, 8'h01, 8'h11);
    exp_acc(3'b010, 1, 8'h02, 8'h22);
    exp_acc(3'b100, 1, 8'h03, 8'h33);
    set_rq(0, 1, 1, 0, 8'h01, 8'h11);
    set_rq(1, 1, 1, 0, 8'h02, 8'h22);
    set_rq(2, 1, 1, 0, 8'h03, 8'h33);
    snap(3'b000, 0, 2'd0, 0, 0, 3'b000, 0, 0);
    tick(); snap(3'b001, 1, 2'd0, 1, 0, 3'b000, 0, 0);
    tick(); bus.req[0] = 1'b0; snap(3'b010, 1, 2'd1, 1, 0, 3'b000, 0, 0);
    tick(); bus.req[1] = 1'b0; snap(3'b100, 1, 2'd2, 1, 0, 3'b000, 0, 0);
    tick(); bus.req[2] = 1'b0; bus.we = 3'b000; snap(3'b000, 0, 2'd2, 0, 0, 3'b000, 0, 0);

    // dither locked read burst 0x10..0x13, unlocked read 0x14 releases
    for (int k = 0; k < 5; k++) exp_acc(3'b010, 0, 8'h10 + 8'(k), 8'h00);
    exp_rd(3'b010, 8'h4A); exp_rd(3'b010, 8'h4B); exp_rd(3'b010, 8'h48);
    exp_rd(3'b010, 8'h49); exp_rd(3'b010, 8'h4E);
    set_rq(1, 1, 0, 1, 8'h10, 8'h00);
    tick(); snap(3'b010, 1, 2'd1, 0, 1, 3'b000, 0, 0);
    for (int k = 1; k < 4; k++) begin
      tick(); bus.addr1 = 8'h10 + 8'(k);
    end
    tick(); bus.addr1 = 8'h14; bus.lock[1] = 1'b0;
    tick(); bus.req[1] = 1'b0; snap(3'b000, 0, 2'd1, 0, 0, 3'b010, 0, 0);
    tick();

    // loader locked write stream, readout arrives at beat 3, preempted after 16
    for (int k = 0; k < 16; k++) exp_acc(3'b001, 1, 8'h20 + 8'(k), 8'h80 + 8'(k));
    exp_acc(3'b100, 0, 8'h05, 8'h00);
    exp_rd(3'b100, 8'h5F);
    set_rq(0, 1, 1, 1, 8'h20, 8'h80);
    for (int k = 0; k < 16; k++) begin
      tick();
      bus.addr0 = 8'h20 + 8'(k); bus.wdata0 = 8'h80 + 8'(k);
      if (k == 2) set_rq(2, 1, 0, 0, 8'h05, 8'h00);
      if (k == 15) snap(3'b001, 1, 2'd0, 1, 0, 3'b000, 0, 0);
    end
    tick(); bus.req[0] = 1'b0; bus.lock[0] = 1'b0; snap(3'b100, 1, 2'd2, 0, 1, 3'b000, 1, 0);
    tick(); bus.req[2] = 1'b0; snap(3'b000, 0, 2'd2, 0, 0, 3'b100, 0, 0);
    tick();

    // dither read released to readout on the same edge: rvalid tags dither
    exp_acc(3'b010, 0, 8'h07, 8'h00);
    exp_acc(3'b100, 1, 8'h30, 8'h99);
    exp_rd(3'b010, 8'h5D);
    set_rq(1, 1, 0, 0, 8'h07, 8'h00);
    set_rq(2, 1, 1, 0, 8'h30, 8'h99);
    tick(); snap(3'b010, 1, 2'd1, 0, 1, 3'b000, 0, 0);
    tick(); bus.req[1] = 1'b0; snap(3'b100, 1, 2'd2, 1, 0, 3'b010, 0, 0);
    tick(); bus.req[2] = 1'b0; bus.we = 3'b000; snap(3'b000, 0, 2'd2, 0, 0, 3'b000, 0, 0);

    // loader one write, 5 locked idle beats, then 15 more writes before preemption
    for (int k = 0; k < 16; k++) exp_acc(3'b001, 1, 8'h40 + 8'(k), 8'h44 + 8'(k));
    exp_acc(3'b100, 0, 8'h06, 8'h00);
    exp_rd(3'b100, 8'h5C);
    set_rq(0, 1, 1, 1, 8'h40, 8'h44);
    tick(); snap(3'b001, 1, 2'd0, 1, 0, 3'b000, 0, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) bus.req[0] = 1'b0;
      snap(3'b001, 1, 2'd0, 0, 0, 3'b000, 0, 0);
    end
    for (int k = 1; k < 16; k++) begin
      tick();
      bus.req[0] = 1'b1; bus.addr0 = 8'h40 + 8'(k); bus.wdata0 = 8'h44 + 8'(k);
      if (k == 1) set_rq(2, 1, 0, 0, 8'h06, 8'h00);
      if (k == 14) snap(3'b001, 1, 2'd0, 1, 0, 3'b000, 0, 0);
      if (k == 15) snap(3'b001, 1, 2'd0, 1, 0, 3'b000, 0, 0);
    end
    tick(); bus.req[0] = 1'b0; bus.lock[0] = 1'b0; snap(3'b100, 1, 2'd2, 0, 1, 3'b000, 1, 0);
    tick(); bus.req[2] = 1'b0; snap(3'b000, 0, 2'd2, 0, 0, 3'b100, 0, 0);
    tick();

    // reset with a dither read in flight, then readout-only request
    exp_acc(3'b010, 0, 8'h08, 8'h00);
    set_rq(1, 1, 0, 1, 8'h08, 8'h00);
    tick(); snap(3'b010, 1, 2'd1, 0, 1, 3'b000, 0, 0);
    tick(); rst = 1'b0; snap(3'b000, 0, 2'd0, 0, 0, 3'b000, 0, 1);
    bus.req = 3'b000; bus.lock = 3'b000;
    tick(); rst = 1'b1;
    tick();
    exp_acc(3'b100, 1, 8'h50, 8'h55);
    set_rq(2, 1, 1, 0, 8'h50, 8'h55);
    tick(); snap(3'b100, 1, 2'd2, 1, 0, 3'b000, 0, 0);
    tick(); bus.req[2] = 1'b0; snap(3'b000, 0, 2'd2, 0, 0, 3'b000, 0, 0);
    tick();
    tick();
    done = 1'b1;
  end

endmodule
